// File: rtl/vga_frame_regs.sv
// vga_frame_regs
//   Frame-synchronous register bank for the sprite renderer. The HPS writes
//   sprite coordinates and score into a shadow bank over Avalon-MM. The active
//   bank that drives the renderer is loaded from the shadow bank only at the
//   start of vertical blank, and only when software has armed a commit, so the
//   renderer never shows a half-updated frame. The block also keeps a frame
//   counter, a frame-locked animation phase and a level vblank interrupt.
//
// Ports
//   clk          system clock, shared with the VGA counters
//   reset        synchronous, active-high
//   chipselect   Avalon slave select
//   write/read   Avalon strobes (never asserted together)
//   address      Avalon word address (9 bits)
//   writedata    Avalon write data (32 bits)
//   readdata     Avalon read data, registered, one cycle after the read strobe
//   hcount       horizontal count from vga_counters
//   vcount       vertical count from vga_counters
//   regs_out     active bank, register i at [i*REG_W +: REG_W]
//   anim_phase   animation frame index, steps once every ANIM_DIV frames
//   frame_count  vblank counter, wraps 0xFFFF -> 0
//   irq          vblank interrupt, level (irq_stat & irq_en)
//
// Address map
//   0 .. NUM_REGS-1  shadow registers (read returns shadow, zero-extended)
//   0x100 CTRL       W: bit0=1 arms commit, bit1 loads irq_en
//                    R: {30'b0, irq_en, commit_pending}
//   0x101 STAT       W: bit0=1 clears irq_stat   R: {31'b0, irq_stat}
//   0x102 FRAME      R: {16'b0, frame_count}, writes ignored
//   others           writes ignored, reads return 0

module vga_frame_regs #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 8,
  parameter int VACTIVE  = 480,
  parameter int ANIM_DIV = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic                      read,
  input  logic [8:0]                address,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic [1:0]                anim_phase,
  output logic [15:0]               frame_count,
  output logic                      irq
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [8:0]       ADDR_CTRL  = 9'h100;
  localparam logic [8:0]       ADDR_STAT  = 9'h101;
  localparam logic [8:0]       ADDR_FRAME = 9'h102;
  localparam logic [8:0]       REG_END    = 9'(NUM_REGS);
  localparam logic [9:0]       VB_LINE    = 10'(VACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] shadow [NUM_REGS];
  logic [REG_W-1:0] active [NUM_REGS];
  logic             commit_pending;
  logic             irq_en;
  logic             irq_stat;
  logic [DIV_W-1:0] div_cnt;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             vb;
  logic             wr;
  logic             rd;
  logic             is_reg;
  logic [IDX_W-1:0] reg_idx;
  logic             ctrl_wr;
  logic             stat_wr;

  // One cycle per frame: the first pixel clock of the first blanked line.
  assign vb      = (vcount == VB_LINE) && (hcount == '0);
  assign wr      = chipselect & write;
  assign rd      = chipselect & read;
  assign is_reg  = (address < REG_END);
  assign reg_idx = address[IDX_W-1:0];
  assign ctrl_wr = wr && (address == ADDR_CTRL);
  assign stat_wr = wr && (address == ADDR_STAT);

  // Upper write-data bits have no destination in this register map.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:REG_W];

  // ---------------------------------------------------------------------------
  // Shadow bank (software side)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of every other flop; that is what gives "active gets
  // the old shadow value" when a shadow write lands on the vb cycle.
  // NOTE: the register banks are reset explicitly because software relies on
  // reading zeros after reset; this forces flops instead of a RAM macro, which
  // is fine at this size.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (wr && is_reg) begin
      shadow[reg_idx] <= writedata[REG_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank (renderer side), loaded only on an armed vblank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) active[i] <= '0;
    end else if (vb && commit_pending) begin
      for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_pending <= 1'b0;
      irq_en         <= 1'b0;
      irq_stat       <= 1'b0;
    end else begin
      // Commit consumes the arm; a CTRL arm in the same cycle is applied
      // afterwards so it re-arms for the next frame instead of being lost.
      if (vb && commit_pending) commit_pending <= 1'b0;
      if (ctrl_wr) begin
        if (writedata[0]) commit_pending <= 1'b1;
        irq_en <= writedata[1];
      end

      // Set is evaluated last so a vblank beats a simultaneous clear.
      if (stat_wr && writedata[0]) irq_stat <= 1'b0;
      if (vb) irq_stat <= 1'b1;
    end
  end

  assign irq = irq_stat & irq_en;

  // ---------------------------------------------------------------------------
  // Frame counter and frame-locked animation divider
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      div_cnt     <= '0;
      anim_phase  <= '0;
    end else if (vb) begin
      frame_count <= frame_count + 16'd1;
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        anim_phase <= anim_phase + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] read_mux;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    read_mux = '0;
    if (is_reg) begin
      read_mux = {{(32-REG_W){1'b0}}, shadow[reg_idx]};
    end else begin
      case (address)
        ADDR_CTRL:  read_mux = {30'b0, irq_en, commit_pending};
        ADDR_STAT:  read_mux = {31'b0, irq_stat};
        ADDR_FRAME: read_mux = {16'b0, frame_count};
        default:    read_mux = '0;
      endcase
    end
  end

  // Registered read data; holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd) begin
      readdata <= read_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank flattening
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*REG_W +: REG_W] = active[i];
  end

endmodule
